// File: rtl/spram_arbiter_pkg.sv
// Shared types and constants for the pixel SPRAM arbiter.
package spram_pkg;
  localparam int PIX_W       = 12;
  localparam int ADDR_W      = 15;
  localparam int IMG_PIX_DEF = 19200;  // 160x120

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/spram_arbiter_if.sv
// Bus bundle between the pixel/display paths, the arbiter and the SPRAM macro.
interface spram_arbiter_if;
  import spram_pkg::*;

  logic              i_start;
  logic              i_pix_valid;
  logic [PIX_W-1:0]  i_pix_data;
  logic              i_rd_req;
  logic [ADDR_W-1:0] i_rd_addr;
  logic [PIX_W-1:0]  o_rd_data;
  logic              o_rd_valid;
  logic [ADDR_W-1:0] o_pix_cnt;
  logic              o_image_complete;
  logic              o_loading;
  logic              o_overflow;
  logic              o_spram_ce;
  logic              o_spram_oce;
  logic              o_spram_rst;
  logic              o_spram_wre;
  logic [ADDR_W-1:0] o_spram_ad;
  logic [PIX_W-1:0]  o_spram_din;
  logic [PIX_W-1:0]  i_spram_dout;

  modport slave (
    input  i_start, i_pix_valid, i_pix_data, i_rd_req, i_rd_addr, i_spram_dout,
    output o_rd_data, o_rd_valid, o_pix_cnt, o_image_complete, o_loading, o_overflow,
           o_spram_ce, o_spram_oce, o_spram_rst, o_spram_wre, o_spram_ad, o_spram_din
  );

  modport master (
    output i_start, i_pix_valid, i_pix_data, i_rd_req, i_rd_addr, i_spram_dout,
    input  o_rd_data, o_rd_valid, o_pix_cnt, o_image_complete, o_loading, o_overflow,
           o_spram_ce, o_spram_oce, o_spram_rst, o_spram_wre, o_spram_ad, o_spram_din
  );
endinterface

// File: rtl/spram_arbiter_fifo.sv
// Small pixel write buffer: DEPTH x PIX_W, show-ahead read, synchronous flush.
module pix_fifo
  import spram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PIX_W-1:0] mem_q [DEPTH];
  logic [PIX_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign dout    = mem_q[rp_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer/count update; flush drops everything buffered.
  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wp_q] = din;
        wp_d        = wp_q + AW'(1);
      end
      if (do_pop) rp_d = rp_q + AW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Control state under reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; stale entries are never read while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/spram_arbiter.sv
// Shares the single-port pixel SPRAM: display reads win, buffered pixel writes
// drain into sequential addresses on idle cycles.
module spram_arbiter
  import spram_pkg::*;
#(
  parameter int IMG_PIX    = IMG_PIX_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input logic            i_clk_sys,
  input logic            i_rst_n,
  spram_arbiter_if.slave bus
);
  localparam int                STAGES  = 1;
  localparam logic [ADDR_W-1:0] LAST_AD = ADDR_W'(IMG_PIX - 1);
  localparam logic [ADDR_W-1:0] IMG_CNT = ADDR_W'(IMG_PIX);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, acc_cnt_q, acc_cnt_d, pix_cnt_q, pix_cnt_d;
  logic [ADDR_W-1:0] ad_q, ad_d;
  logic [PIX_W-1:0]  din_q, din_d;
  logic              ovf_q, ovf_d, cmp_q, cmp_d, loading_q, loading_d;
  logic              ce_q, ce_d, wre_q, wre_d, srst_q, srst_d;
  logic [STAGES:0]   vld_pipe_q, vld_pipe_d;

  logic             fifo_full, fifo_empty;
  logic [PIX_W-1:0] fifo_dout;
  logic             push_try, push_ok, pop, last_wr;

  // Pixels only enter in LOAD; start steals the cycle so its pixel is lost quietly.
  assign push_try = (state_q == ST_LOAD) && bus.i_pix_valid && !bus.i_start;
  assign push_ok  = push_try && !fifo_full && (acc_cnt_q < IMG_CNT);
  assign pop      = !bus.i_rd_req && !fifo_empty && !bus.i_start;
  assign last_wr  = pop && (wr_ptr_q == LAST_AD);

  pix_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (i_clk_sys),
    .rst_n (i_rst_n),
    .flush (bus.i_start),
    .push  (push_ok),
    .pop   (pop),
    .din   (bus.i_pix_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state: FSM, counters, and the SPRAM command chosen this cycle.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    acc_cnt_d = acc_cnt_q;
    pix_cnt_d = pix_cnt_q;
    ovf_d     = ovf_q;
    if (bus.i_start) begin
      state_d   = ST_LOAD;
      wr_ptr_d  = '0;
      acc_cnt_d = '0;
      pix_cnt_d = '0;
      ovf_d     = 1'b0;
    end else begin
      if (state_q == ST_LOAD && last_wr) state_d = ST_DONE;
      if (pop && wr_ptr_q != LAST_AD) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (push_ok) acc_cnt_d = acc_cnt_q + ADDR_W'(1);
      if (push_try && !push_ok) ovf_d = 1'b1;
      // Counts commits, i.e. the write that is on the pins right now.
      if (wre_q) pix_cnt_d = pix_cnt_q + ADDR_W'(1);
    end
    cmp_d      = last_wr && (state_q == ST_LOAD);
    loading_d  = (state_d == ST_LOAD);
    ce_d       = bus.i_rd_req || pop;
    wre_d      = pop;
    ad_d       = bus.i_rd_req ? bus.i_rd_addr : (pop ? wr_ptr_q : ad_q);
    din_d      = pop ? fifo_dout : din_q;
    srst_d     = 1'b0;
    vld_pipe_d = {vld_pipe_q[STAGES-1:0], bus.i_rd_req};
  end

  // Single state register for FSM, counters and registered SPRAM pins.
  always_ff @(posedge i_clk_sys) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      acc_cnt_q  <= '0;
      pix_cnt_q  <= '0;
      ovf_q      <= 1'b0;
      cmp_q      <= 1'b0;
      loading_q  <= 1'b0;
      ce_q       <= 1'b0;
      wre_q      <= 1'b0;
      ad_q       <= '0;
      din_q      <= '0;
      srst_q     <= 1'b1;
      vld_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      acc_cnt_q  <= acc_cnt_d;
      pix_cnt_q  <= pix_cnt_d;
      ovf_q      <= ovf_d;
      cmp_q      <= cmp_d;
      loading_q  <= loading_d;
      ce_q       <= ce_d;
      wre_q      <= wre_d;
      ad_q       <= ad_d;
      din_q      <= din_d;
      srst_q     <= srst_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  assign bus.o_rd_data        = bus.i_spram_dout;
  assign bus.o_rd_valid       = vld_pipe_q[STAGES];
  assign bus.o_pix_cnt        = pix_cnt_q;
  assign bus.o_image_complete = cmp_q;
  assign bus.o_loading        = loading_q;
  assign bus.o_overflow       = ovf_q;
  assign bus.o_spram_ce       = ce_q;
  assign bus.o_spram_oce      = 1'b1;
  assign bus.o_spram_rst      = srst_q;
  assign bus.o_spram_wre      = wre_q;
  assign bus.o_spram_ad       = ad_q;
  assign bus.o_spram_din      = din_q;
endmodule

// File: tb/tb_spram_arbiter.sv
// Directed bench for spram_arbiter with an SPRAM model and write/read scoreboards.
module tb_spram_arbiter;
  localparam int IMG = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spram_arbiter_if bus ();

  spram_arbiter #(.IMG_PIX(IMG), .FIFO_DEPTH(4)) dut (
    .i_clk_sys (clk),
    .i_rst_n   (rst_n),
    .bus       (bus)
  );

  // SPRAM model: registered read in bypass mode, plus a preload port.
  logic [11:0] mem [0:32767];
  logic [11:0] dout_q = '0;
  logic        pre_we = 1'b0;
  logic [14:0] pre_addr = '0;
  logic [11:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus.o_spram_ce && bus.o_spram_wre) mem[bus.o_spram_ad] <= bus.o_spram_din;
    if (bus.o_spram_ce && !bus.o_spram_wre) dout_q <= mem[bus.o_spram_ad];
  end
  assign bus.i_spram_dout = dout_q;

  typedef struct packed { logic [14:0] ad; logic [11:0] d; } wr_t;
  typedef struct packed { logic [11:0] d; logic [31:0] due; } rd_t;
  wr_t wq[$];
  rd_t rq[$];

  int          n_assert = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          cmp_cnt = 0;
  logic [14:0] exp_wa = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    wr_t w;
    rd_t r;
    chk("cmp_pulse", 32'(bus.o_image_complete),
        32'(bus.o_spram_wre && (bus.o_spram_ad == 15'(IMG - 1))));
    if (bus.o_image_complete) cmp_cnt++;
    if (bus.o_spram_wre) begin
      chk("wr_expected", 32'(wq.size() != 0), 32'd1);
      if (wq.size() != 0) begin
        w = wq.pop_front();
        chk("wr_ad", 32'(bus.o_spram_ad), 32'(w.ad));
        chk("wr_din", 32'(bus.o_spram_din), 32'(w.d));
        chk("wr_ce", 32'(bus.o_spram_ce), 32'd1);
      end
    end
    if (bus.o_rd_valid) begin
      chk("rd_expected", 32'(rq.size() != 0), 32'd1);
      if (rq.size() != 0) begin
        r = rq.pop_front();
        chk("rd_data", 32'(bus.o_rd_data), 32'(r.d));
        chk("rd_latency", 32'(cyc), r.due);
      end
    end else if (rq.size() != 0 && rq[0].due <= 32'(cyc)) begin
      chk("rd_missing", 32'(bus.o_rd_valid), 32'd1);
      void'(rq.pop_front());
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drive(input bit st, input bit pv, input logic [11:0] pd, input bit wexp,
                       input bit rr, input logic [14:0] ra, input logic [11:0] rexp,
                       input bit rchk);
    bus.i_start     = st;
    bus.i_pix_valid = pv;
    bus.i_pix_data  = pd;
    bus.i_rd_req    = rr;
    bus.i_rd_addr   = ra;
    if (st) exp_wa = '0;
    if (wexp) begin
      wq.push_back({exp_wa, pd});
      exp_wa = exp_wa + 15'd1;
    end
    if (rr && rchk) rq.push_back({rexp, 32'(cyc + 2)});
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, '0, 0, 0, '0, '0, 0);
  endtask

  initial begin
    bus.i_start = 0; bus.i_pix_valid = 0; bus.i_pix_data = '0;
    bus.i_rd_req = 0; bus.i_rd_addr = '0;

    // Reset, preloading the read-only pattern while held.
    for (int i = 0; i < 17; i++) begin
      pre_we   = 1'b1;
      pre_addr = (i == 16) ? 15'h0010 : 15'(16'h0100 + i);
      pre_data = (i == 16) ? 12'hABC : 12'(16'h0300 + i);
      tick();
    end
    pre_we = 1'b0;
    chk("rst_ce", 32'(bus.o_spram_ce), 0);
    chk("rst_wre", 32'(bus.o_spram_wre), 0);
    chk("rst_rd_valid", 32'(bus.o_rd_valid), 0);
    chk("rst_cmp", 32'(bus.o_image_complete), 0);
    chk("rst_ovf", 32'(bus.o_overflow), 0);
    chk("rst_loading", 32'(bus.o_loading), 0);
    chk("rst_ad", 32'(bus.o_spram_ad), 0);
    chk("rst_din", 32'(bus.o_spram_din), 0);
    chk("rst_pix_cnt", 32'(bus.o_pix_cnt), 0);
    chk("rst_spram_rst", 32'(bus.o_spram_rst), 1);
    chk("rst_oce", 32'(bus.o_spram_oce), 1);
    rst_n = 1'b1;
    idle(1);
    chk("spram_rst_off", 32'(bus.o_spram_rst), 0);

    // Read path: command on pins next cycle, data two cycles after request.
    drive(0, 0, '0, 0, 1, 15'h0010, 12'hABC, 1);
    chk("rdp_ce", 32'(bus.o_spram_ce), 1);
    chk("rdp_wre", 32'(bus.o_spram_wre), 0);
    chk("rdp_ad", 32'(bus.o_spram_ad), 32'h10);
    chk("rdp_valid_early", 32'(bus.o_rd_valid), 0);
    idle(1);
    chk("rdp_valid", 32'(bus.o_rd_valid), 1);
    chk("rdp_data", 32'(bus.o_rd_data), 32'hABC);
    chk("rdp_ce_idle", 32'(bus.o_spram_ce), 0);
    chk("rdp_ad_hold", 32'(bus.o_spram_ad), 32'h10);
    idle(2);

    // Full image load, pixels spaced 3 cycles apart.
    drive(1, 0, '0, 0, 0, '0, '0, 0);
    chk("load_loading", 32'(bus.o_loading), 1);
    chk("load_cnt0", 32'(bus.o_pix_cnt), 0);
    for (int k = 0; k < IMG; k++) begin
      drive(0, 1, 12'hA50 ^ 12'(k), 1, 0, '0, '0, 0);
      if (k == 0) chk("wr_lat_n1", 32'(bus.o_spram_wre), 0);
      idle(1);
      if (k == 0) begin
        chk("wr_lat_n2", 32'(bus.o_spram_wre), 1);
        chk("wr_lat_ad", 32'(bus.o_spram_ad), 0);
        chk("wr_lat_cnt", 32'(bus.o_pix_cnt), 0);
      end
      idle(1);
      if (k == 0) chk("wr_cnt_after", 32'(bus.o_pix_cnt), 1);
    end
    idle(3);
    chk("load_pix_cnt", 32'(bus.o_pix_cnt), 32'(IMG));
    chk("load_cmp_once", 32'(cmp_cnt), 1);
    chk("load_done", 32'(bus.o_loading), 0);
    for (int k = 0; k < IMG; k++)
      chk("load_mem", 32'(mem[15'(k)]), 32'(12'hA50 ^ 12'(k)));
    drive(0, 1, 12'h111, 0, 0, '0, '0, 0);
    idle(4);
    chk("done_ignore_ovf", 32'(bus.o_overflow), 0);
    chk("done_ignore_cnt", 32'(bus.o_pix_cnt), 32'(IMG));

    // Read priority: 10-cycle read burst with 3 pixels buffered.
    drive(1, 0, '0, 0, 0, '0, '0, 0);
    for (int j = 0; j < 10; j++) begin
      drive(0, j < 3, 12'(12'h7C0 + j), j < 3, 1, 15'(16'h0100 + j), 12'(12'h300 + j), 1);
      chk("prio_no_wr", 32'(bus.o_spram_wre), 0);
    end
    for (int j = 0; j < 3; j++) begin
      idle(1);
      chk("prio_wr", 32'(bus.o_spram_wre), 1);
      chk("prio_ad", 32'(bus.o_spram_ad), 32'(j));
    end
    chk("prio_ovf", 32'(bus.o_overflow), 0);
    idle(2);

    // Overflow: fifth pixel behind a full buffer is dropped.
    drive(1, 0, '0, 0, 0, '0, '0, 0);
    for (int j = 0; j < 5; j++)
      drive(0, 1, 12'(12'h5A0 + j), j < 4, 1, 15'(16'h0108 + j), 12'(12'h308 + j), 1);
    chk("ovf_set", 32'(bus.o_overflow), 1);
    idle(7);
    chk("ovf_sticky", 32'(bus.o_overflow), 1);
    chk("ovf_cnt", 32'(bus.o_pix_cnt), 4);
    drive(1, 0, '0, 0, 0, '0, '0, 0);
    chk("ovf_clear", 32'(bus.o_overflow), 0);
    chk("ovf_cnt_clear", 32'(bus.o_pix_cnt), 0);

    // Restart mid-load, start coincident with a pixel.
    for (int j = 0; j < 10; j++) begin
      drive(0, 1, 12'(12'h200 + j), 1, 0, '0, '0, 0);
      idle(1);
    end
    idle(3);
    chk("rs_cnt10", 32'(bus.o_pix_cnt), 10);
    drive(1, 1, 12'hEEE, 0, 0, '0, '0, 0);
    chk("rs_cnt0", 32'(bus.o_pix_cnt), 0);
    chk("rs_ovf", 32'(bus.o_overflow), 0);
    chk("rs_loading", 32'(bus.o_loading), 1);
    idle(4);
    chk("rs_no_wr_cnt", 32'(bus.o_pix_cnt), 0);
    drive(0, 1, 12'h123, 1, 0, '0, '0, 0);
    idle(4);
    chk("rs_next_cnt", 32'(bus.o_pix_cnt), 1);
    chk("rs_next_mem", 32'(mem[0]), 32'h123);

    // Reset mid-load with two pixels buffered behind reads.
    for (int j = 0; j < 4; j++)
      drive(0, j < 2, 12'(12'h9F0 + j), 0, 1, 15'(16'h0104 + j), 12'(12'h304 + j), j < 3);
    rst_n = 1'b0;
    idle(1);
    chk("mr_ce", 32'(bus.o_spram_ce), 0);
    chk("mr_wre", 32'(bus.o_spram_wre), 0);
    chk("mr_rd_valid", 32'(bus.o_rd_valid), 0);
    chk("mr_ovf", 32'(bus.o_overflow), 0);
    chk("mr_loading", 32'(bus.o_loading), 0);
    chk("mr_ad", 32'(bus.o_spram_ad), 0);
    chk("mr_din", 32'(bus.o_spram_din), 0);
    chk("mr_cnt", 32'(bus.o_pix_cnt), 0);
    chk("mr_spram_rst", 32'(bus.o_spram_rst), 1);
    rst_n = 1'b1;
    idle(6);
    chk("mr_after_cnt", 32'(bus.o_pix_cnt), 0);
    chk("mr_after_srst", 32'(bus.o_spram_rst), 0);
    chk("mr_mem_kept", 32'(mem[0]), 32'h123);

    chk("wq_drained", 32'(wq.size()), 0);
    chk("rq_drained", 32'(rq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
